// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one holding buffer per functional unit, one
// registered scoreboard writeback per cycle.
module wb_arbiter #(
  parameter int unsigned NR_REQ        = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned EX_WIDTH      = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NR_REQ-1:0]                 req_valid_i,
  output logic [NR_REQ-1:0]                 req_ready_o,
  input  logic [NR_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i,
  input  logic [NR_REQ*DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [NR_REQ*EX_WIDTH-1:0]        req_ex_i,
  output logic                              wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]          trans_id_o,
  output logic [DATA_WIDTH-1:0]             wdata_o,
  output logic [EX_WIDTH-1:0]               ex_o,
  output logic                              busy_o
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [NR_REQ-1:0]                     buf_valid_q, buf_valid_d;
  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]  buf_tid_q, buf_tid_d;
  logic [NR_REQ-1:0][DATA_WIDTH-1:0]     buf_wdata_q, buf_wdata_d;
  logic [NR_REQ-1:0][EX_WIDTH-1:0]       buf_ex_q, buf_ex_d;
  logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                                  wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0]              trans_id_q, trans_id_d;
  logic [DATA_WIDTH-1:0]                 wdata_q, wdata_d;
  logic [EX_WIDTH-1:0]                   ex_q, ex_d;

  logic [NR_REQ-1:0]                     grant_s;
  logic [NR_REQ-1:0]                     hs_s;
  logic [PTR_W-1:0]                      gnt_idx_s;
  logic                                  gnt_found_s;
  logic [PTR_W:0]                        idx_s;
  logic                                  take_s;

  // Round-robin search for the first valid buffer starting at rr_ptr.
  always_comb begin
    grant_s     = '0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx_s >= (PTR_W+1)'(NR_REQ)) begin
        idx_s = idx_s - (PTR_W+1)'(NR_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_found_s && buf_valid_q[idx_s[PTR_W-1:0]]) begin
        grant_s[idx_s[PTR_W-1:0]] = 1'b1;
        gnt_idx_s                 = idx_s[PTR_W-1:0];
        gnt_found_s               = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign req_ready_o = flush_i ? '0 : (~buf_valid_q | grant_s);
  assign hs_s        = req_valid_i & req_ready_o;
  assign take_s      = gnt_found_s && !flush_i;

  // Buffer, pointer and output-register next state.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tid_d   = buf_tid_q;
    buf_wdata_d = buf_wdata_q;
    buf_ex_d    = buf_ex_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (hs_s[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_tid_d[i]   = req_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
        buf_wdata_d[i] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        buf_ex_d[i]    = req_ex_i[i*EX_WIDTH +: EX_WIDTH];
      end else if (grant_s[i]) begin
        buf_valid_d[i] = 1'b0;
      end else begin
        buf_valid_d[i] = buf_valid_q[i];
      end
    end
    if (flush_i) begin
      buf_valid_d = '0;
    end else begin
      buf_valid_d = buf_valid_d;
    end

    // A grant computed during a flush is discarded; pointer and data hold.
    if (take_s) begin
      wb_valid_d = 1'b1;
      trans_id_d = buf_tid_q[gnt_idx_s];
      wdata_d    = buf_wdata_q[gnt_idx_s];
      ex_d       = buf_ex_q[gnt_idx_s];
      if (gnt_idx_s == PTR_W'(NR_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      wb_valid_d = 1'b0;
      trans_id_d = trans_id_q;
      wdata_d    = wdata_q;
      ex_d       = ex_q;
      rr_ptr_d   = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= '0;
      buf_tid_q   <= '0;
      buf_wdata_q <= '0;
      buf_ex_q    <= '0;
      rr_ptr_q    <= '0;
      wb_valid_q  <= 1'b0;
      trans_id_q  <= '0;
      wdata_q     <= '0;
      ex_q        <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tid_q   <= buf_tid_d;
      buf_wdata_q <= buf_wdata_d;
      buf_ex_q    <= buf_ex_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_valid_q  <= wb_valid_d;
      trans_id_q  <= trans_id_d;
      wdata_q     <= wdata_d;
      ex_q        <= ex_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign trans_id_o = trans_id_q;
  assign wdata_o    = wdata_q;
  assign ex_o       = ex_q;
  assign busy_o     = (|buf_valid_q) | wb_valid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector table plus a scoreboarded random-traffic phase for wb_arbiter.
module tb_wb_arbiter;

  localparam int NR = 4;
  localparam int TB = 3;
  localparam int DW = 64;
  localparam int EW = 64;

  logic               clk_i;
  logic               rst_i;
  logic               flush_i;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0]      req_ready_o;
  logic [NR*TB-1:0]   req_trans_id_i;
  logic [NR*DW-1:0]   req_wdata_i;
  logic [NR*EW-1:0]   req_ex_i;
  logic               wb_valid_o;
  logic [TB-1:0]      trans_id_o;
  logic [DW-1:0]      wdata_o;
  logic [EW-1:0]      ex_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NR_REQ(NR), .TRANS_ID_BITS(TB), .DATA_WIDTH(DW), .EX_WIDTH(EW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_trans_id_i(req_trans_id_i), .req_wdata_i(req_wdata_i), .req_ex_i(req_ex_i),
    .wb_valid_o(wb_valid_o), .trans_id_o(trans_id_o), .wdata_o(wdata_o),
    .ex_o(ex_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             rst;
    logic             flush;
    logic [3:0]       vld;
    logic [3:0][2:0]  tid;
    logic [3:0]       ex_rdy;
    logic             ex_wb;
    logic [2:0]       ex_tid;
    logic [3:0]       ex_src;   // 4'hF: output data expected all zero
    logic             ex_busy;
    logic [1:0]       ex_rr;
  } vec_t;

  typedef struct {
    int tag;
    int cyc;
  } pend_t;

  vec_t  vq[$];
  pend_t pend[$];

  function automatic logic [63:0] pay(int i, logic [2:0] t);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(t);
  endfunction

  function automatic vec_t mk(logic rst, logic flush, logic [3:0] vld,
                              logic [2:0] t3, logic [2:0] t2, logic [2:0] t1, logic [2:0] t0,
                              logic [3:0] rdy, logic wb, logic [2:0] etid, logic [3:0] esrc,
                              logic busy, logic [1:0] rr);
    vec_t v;
    v.rst = rst; v.flush = flush; v.vld = vld;
    v.tid = {t3, t2, t1, t0};
    v.ex_rdy = rdy; v.ex_wb = wb; v.ex_tid = etid; v.ex_src = esrc;
    v.ex_busy = busy; v.ex_rr = rr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_d;
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [3:0]  hs;
    int          tag [4];
    int          next_tag;
    int          cyc;
    bit          found;
    bit          ok;
    int          lat;

    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0;
    req_trans_id_i = '0; req_wdata_i = '0; req_ex_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_trans_id", 64'(trans_id_o), 64'd0);
    chk("rst_wdata",    wdata_o, 64'd0);
    chk("rst_ex",       ex_o, 64'd0);
    chk("rst_busy",     64'(busy_o), 64'd0);
    chk("rst_rr_ptr",   64'(dut.rr_ptr_q), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'hF);

    //        rst flush vld      t3 t2 t1 t0  rdy      wb tid src    busy rr
    vq.push_back(mk(0, 0, 4'b0100, 0, 5, 0, 0, 4'b1111, 0, 0, 4'hF, 1, 0));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 5, 4'd2, 1, 3));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 5, 4'd2, 0, 3));
    vq.push_back(mk(0, 0, 4'b1000, 1, 0, 0, 0, 4'b1111, 0, 5, 4'd2, 1, 3));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 1, 4'd3, 1, 0));
    vq.push_back(mk(0, 0, 4'b1111, 6, 4, 3, 2, 4'b1111, 0, 1, 4'd3, 1, 0));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 1, 2, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0011, 1, 3, 4'd1, 1, 2));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0111, 1, 4, 4'd2, 1, 3));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 6, 4'd3, 1, 0));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 6, 4'd3, 0, 0));
    vq.push_back(mk(0, 0, 4'b0011, 0, 0, 2, 1, 4'b1111, 0, 6, 4'd3, 1, 0));
    vq.push_back(mk(0, 0, 4'b0011, 0, 0, 4, 3, 4'b1101, 1, 1, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0011, 0, 0, 4, 5, 4'b1110, 1, 2, 4'd1, 1, 2));
    vq.push_back(mk(0, 0, 4'b0011, 0, 0, 6, 5, 4'b1101, 1, 3, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0010, 0, 0, 6, 0, 4'b1110, 1, 4, 4'd1, 1, 2));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1101, 1, 5, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 6, 4'd1, 1, 2));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 6, 4'd1, 0, 2));
    vq.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 1, 4'b1111, 0, 6, 4'd1, 1, 2));
    vq.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 2, 4'b1111, 1, 1, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 3, 4'b1111, 1, 2, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 3, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 3, 4'd0, 0, 1));
    vq.push_back(mk(0, 0, 4'b1010, 5, 0, 4, 0, 4'b1111, 0, 3, 4'd0, 1, 1));
    vq.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 7, 4'b0000, 0, 3, 4'd0, 0, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 3, 4'd0, 0, 1));
    vq.push_back(mk(0, 0, 4'b0111, 0, 3, 2, 1, 4'b1111, 0, 3, 4'd0, 1, 1));
    vq.push_back(mk(1, 0, 4'b1000, 4, 0, 0, 0, 4'b1010, 0, 0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 6, 4'b1111, 0, 0, 4'hF, 1, 0));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 6, 4'd0, 1, 1));
    vq.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 6, 4'd0, 0, 1));

    foreach (vq[n]) begin
      @(negedge clk_i);
      rst_i = vq[n].rst;
      flush_i = vq[n].flush;
      req_valid_i = vq[n].vld;
      for (int i = 0; i < NR; i++) begin
        req_trans_id_i[i*TB +: TB] = vq[n].tid[i];
        req_wdata_i[i*DW +: DW]    = pay(i, vq[n].tid[i]);
        req_ex_i[i*EW +: EW]       = ~pay(i, vq[n].tid[i]);
      end
      #1;
      chk($sformatf("v%0d_ready", n), 64'(req_ready_o), 64'(vq[n].ex_rdy));
      @(posedge clk_i);
      #1;
      exp_d = (vq[n].ex_src == 4'hF) ? 64'd0 : pay(int'(vq[n].ex_src), vq[n].ex_tid);
      chk($sformatf("v%0d_wb_valid", n), 64'(wb_valid_o), 64'(vq[n].ex_wb));
      chk($sformatf("v%0d_trans_id", n), 64'(trans_id_o), 64'(vq[n].ex_tid));
      chk($sformatf("v%0d_wdata", n), wdata_o, exp_d);
      chk($sformatf("v%0d_ex", n), ex_o, (vq[n].ex_src == 4'hF) ? 64'd0 : ~exp_d);
      chk($sformatf("v%0d_busy", n), 64'(busy_o), 64'(vq[n].ex_busy));
      chk($sformatf("v%0d_rr_ptr", n), 64'(dut.rr_ptr_q), 64'(vq[n].ex_rr));
    end

    // Random traffic: every accepted tag must come out once, within NR cycles.
    vld = '0; next_tag = 1; cyc = 0;
    for (int i = 0; i < NR; i++) tag[i] = 0;
    for (int c = 0; c < 3000 + 10; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0; flush_i = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (c < 3000 && !vld[i] && ($urandom_range(0, 1) == 1)) begin
          vld[i] = 1'b1;
          tag[i] = next_tag;
          next_tag++;
        end
        req_trans_id_i[i*TB +: TB] = tag[i][2:0];
        req_wdata_i[i*DW +: DW]    = {32'hC3C3_0000, tag[i]};
        req_ex_i[i*EW +: EW]       = ~{32'hC3C3_0000, tag[i]};
      end
      req_valid_i = vld;
      #1;
      rdy = req_ready_o;
      hs = vld & rdy;
      @(posedge clk_i);
      cyc++;
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          pend.push_back('{tag: tag[i], cyc: cyc});
          vld[i] = 1'b0;
        end
      end
      if (wb_valid_o) begin
        found = 1'b0; ok = 1'b0; lat = -1;
        for (int p = 0; p < pend.size(); p++) begin
          if (!found && pend[p].tag == int'(wdata_o[31:0])) begin
            found = 1'b1;
            lat = cyc - pend[p].cyc;
            ok = (lat >= 1) && (lat <= NR) && (wdata_o[63:32] == 32'hC3C3_0000) &&
                 (trans_id_o == wdata_o[2:0]) && (ex_o == ~wdata_o);
            pend.delete(p);
          end
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rand_wb tag=%0d found=%0d latency=%0d tid=%0d ex=%h required: pending tag, latency 1..%0d",
                   wdata_o[31:0], found, lat, trans_id_o, ex_o, NR);
        end
      end
    end
    chk("rand_drained", 64'(pend.size()), 64'd0);
    chk("rand_idle_busy", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
